// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and BTB index/tag helpers.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  // tag is zero-extended to XLEN so lookups compare against btb_tag() directly
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  function automatic logic [XLEN-1:0] btb_idx(input logic [XLEN-1:0] pc, input int idx_w);
    return (pc >> 2) & ((XLEN'(1) << idx_w) - XLEN'(1));
  endfunction

  function automatic logic [XLEN-1:0] btb_tag(input logic [XLEN-1:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: one combinational lookup port, one write port.
module btb_dm
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rd_pc,
  output btb_entry_t      rd_entry,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             unused_tgt_lsb;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [XLEN-3:0]    tgt_q [ENTRIES];
  logic [XLEN-3:0]    tgt_d [ENTRIES];

  assign rd_idx         = IDX_W'(btb_idx(rd_pc, IDX_W));
  assign wr_idx         = IDX_W'(btb_idx(wr_pc, IDX_W));
  assign wr_tag         = TAG_W'(btb_tag(wr_pc, IDX_W));
  assign unused_tgt_lsb = ^wr_target[1:0];

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = XLEN'(tag_q[rd_idx]);
    rd_entry.target = {tgt_q[rd_idx], 2'b00};
  end

  // reads above see pre-edge contents, so a same-cycle write is visible next cycle
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      tgt_d[wr_idx]   = wr_target[XLEN-1:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with BTB-driven next-PC selection and saturating perf counters.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int              BTB_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = fetch_pkg::RESET_PC,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             yags_taken_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_taken_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] btb_hit_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] btb_hit_cnt_q, btb_hit_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  btb_entry_t       lookup;
  logic             hit;
  logic             hit_applied;
  logic             unused_redirect_lsb;

  btb_dm #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (pc_q),
    .rd_entry  (lookup),
    .wr_en     (upd_valid_i & upd_taken_i),
    .wr_pc     (upd_pc_i),
    .wr_target (upd_target_i)
  );

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign hit           = lookup.valid && (lookup.tag == btb_tag(pc_q, IDX_W));
  assign pred_taken_o  = hit & yags_taken_i;
  assign pred_target_o = hit ? lookup.target : '0;
  assign flush_o       = redirect_i & reset;
  assign hit_applied   = pred_taken_o & ~stall_i & ~redirect_i;

  assign pc_o           = pc_q;
  assign btb_hit_cnt_o  = btb_hit_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;

  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (redirect_i)        pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    else if (stall_i)      pc_d = pc_q;
    else if (pred_taken_o) pc_d = pred_target_o;
  end

  always_comb begin
    btb_hit_cnt_d  = btb_hit_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (hit_applied && (btb_hit_cnt_q != '1))  btb_hit_cnt_d  = btb_hit_cnt_q + 1'b1;
    if (redirect_i && (redirect_cnt_q != '1))  redirect_cnt_d = redirect_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= RESET_PC;
      btb_hit_cnt_q  <= '0;
      redirect_cnt_q <= '0;
    end else begin
      pc_q           <= pc_d;
      btb_hit_cnt_q  <= btb_hit_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a per-cycle reference model and literal spot checks.
module tb_fetch_pc_gen;

  localparam int CNT_W   = 2;
  localparam int ENTRIES = 64;
  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        yags_taken_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_o;
  logic [CNT_W-1:0] btb_hit_cnt_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  fetch_pc_gen #(
    .BTB_ENTRIES (ENTRIES),
    .RESET_PC    (32'h0),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .yags_taken_i   (yags_taken_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_target_i   (upd_target_i),
    .upd_taken_i    (upd_taken_i),
    .pc_o           (pc_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .flush_o        (flush_o),
    .btb_hit_cnt_o  (btb_hit_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: BTB as arrays indexed by (pc/4) mod ENTRIES, tag = pc/(4*ENTRIES)
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [31:0] m_pc = 32'h0;
  int          m_hit_cnt = 0;
  int          m_red_cnt = 0;
  bit          mdl_ptk;
  logic [31:0] mdl_tgt;
  int          mdl_wi;

  function automatic int mi(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit m_hit();
    return m_valid[mi(m_pc)] && (m_tag[mi(m_pc)] == m_pc / (4 * ENTRIES));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h0;
      m_hit_cnt = 0;
      m_red_cnt = 0;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else begin
      mdl_ptk = m_hit() && yags_taken_i;
      mdl_tgt = m_tgt[mi(m_pc)];
      if (redirect_i && m_red_cnt < CNT_MAX) m_red_cnt++;
      if (mdl_ptk && !stall_i && !redirect_i && m_hit_cnt < CNT_MAX) m_hit_cnt++;
      if (upd_valid_i && upd_taken_i) begin
        mdl_wi = mi(upd_pc_i);
        m_valid[mdl_wi] = 1'b1;
        m_tag[mdl_wi]   = upd_pc_i / (4 * ENTRIES);
        m_tgt[mdl_wi]   = upd_target_i & 32'hFFFF_FFFC;
      end
      if (redirect_i)   m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      else if (stall_i) m_pc = m_pc;
      else if (mdl_ptk) m_pc = mdl_tgt;
      else              m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    chk("mdl_pc", pc_o, m_pc);
    chk("mdl_pred_taken", 32'(pred_taken_o), 32'(m_hit() && yags_taken_i));
    chk("mdl_pred_target", pred_target_o, m_hit() ? m_tgt[mi(m_pc)] : 32'h0);
    chk("mdl_flush", 32'(flush_o), 32'(redirect_i && reset));
    chk("mdl_hit_cnt", 32'(btb_hit_cnt_o), 32'(m_hit_cnt));
    chk("mdl_red_cnt", 32'(redirect_cnt_o), 32'(m_red_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    step();
    redirect_i = 1'b0;
  endtask

  initial begin
    // redirect during reset must not flush
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    step();
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    redirect_i = 1'b0;
    step();
    reset = 1'b1;

    chk("t1_pc0", pc_o, 32'h0);
    step(); chk("t1_pc4", pc_o, 32'h4);
    step(); chk("t1_pc8", pc_o, 32'h8);
    upd_valid_i = 1'b1; upd_pc_i = 32'h10; upd_target_i = 32'h40; upd_taken_i = 1'b1;
    step(); chk("t1_pcc", pc_o, 32'hC);
    chk("t1_hit_cnt", 32'(btb_hit_cnt_o), 32'h0);
    step(); chk("t2_pc10", pc_o, 32'h10);
    upd_valid_i = 1'b0;
    yags_taken_i = 1'b1;
    #1;
    chk("t2_pred_taken", 32'(pred_taken_o), 32'h1);
    chk("t2_pred_target", pred_target_o, 32'h40);
    step(); chk("t2_pc40", pc_o, 32'h40);
    chk("t2_hit_cnt", 32'(btb_hit_cnt_o), 32'h1);
    yags_taken_i = 1'b0;

    redirect_i = 1'b1; redirect_pc_i = 32'h10;
    #1;
    chk("t3_flush", 32'(flush_o), 32'h1);
    step(); redirect_i = 1'b0;
    chk("t3_pc10", pc_o, 32'h10);
    chk("t3_red_cnt", 32'(redirect_cnt_o), 32'h1);
    #1;
    chk("t3_no_pred", 32'(pred_taken_o), 32'h0);
    step(); chk("t3_pc14", pc_o, 32'h14);

    stall_i = 1'b1;
    redir(32'h200);
    chk("t4_pc200", pc_o, 32'h200);
    chk("t4_red_cnt", 32'(redirect_cnt_o), 32'h2);
    step(); chk("t4_stall_hold", pc_o, 32'h200);
    stall_i = 1'b0;

    redir(32'h110);
    chk("t5_pc110", pc_o, 32'h110);
    yags_taken_i = 1'b1;
    #1;
    chk("t5_alias_pred", 32'(pred_taken_o), 32'h0);
    chk("t5_alias_tgt", pred_target_o, 32'h0);
    step(); chk("t5_pc114", pc_o, 32'h114);
    yags_taken_i = 1'b0;

    redir(32'h13);
    chk("t9_pc_align", pc_o, 32'h10);
    chk("t9_red_sat", 32'(redirect_cnt_o), 32'h3);
    yags_taken_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_target_i = 32'h10; upd_taken_i = 1'b1;
    step(); upd_valid_i = 1'b0;
    chk("t9_hit2", 32'(btb_hit_cnt_o), 32'h2);
    step(); chk("t9_pc10", pc_o, 32'h10);
    chk("t9_hit3", 32'(btb_hit_cnt_o), 32'h3);
    step(); chk("t9_pc40", pc_o, 32'h40);
    chk("t9_hit_sat", 32'(btb_hit_cnt_o), 32'h3);

    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_target_i = 32'h80; upd_taken_i = 1'b1;
    #1;
    chk("t7_old_tgt", pred_target_o, 32'h10);
    step(); upd_valid_i = 1'b0;
    chk("t7_pc10", pc_o, 32'h10);
    step(); chk("t7_pc40", pc_o, 32'h40);
    chk("t7_new_tgt", pred_target_o, 32'h80);
    step(); chk("t7_pc80", pc_o, 32'h80);
    yags_taken_i = 1'b0;

    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_target_i = 32'h100; upd_taken_i = 1'b0;
    redir(32'h40);
    upd_valid_i = 1'b0;
    chk("nt_keep_tgt", pred_target_o, 32'h80);

    redir(32'hFFFF_FFFC);
    chk("t8_pc_top", pc_o, 32'hFFFF_FFFC);
    step(); chk("t8_wrap", pc_o, 32'h0);
    step(); chk("t6_pre_pc4", pc_o, 32'h4);

    #2 reset = 1'b0;
    #1;
    chk("t6_async_pc", pc_o, 32'h0);
    chk("t6_async_cnt", 32'(redirect_cnt_o), 32'h0);
    step();
    reset = 1'b1;
    chk("t6_first_pc", pc_o, 32'h0);
    step(); chk("t6_pc4", pc_o, 32'h4);
    redir(32'h10);
    yags_taken_i = 1'b1;
    #1;
    chk("t6_btb_cleared", 32'(pred_taken_o), 32'h0);
    step(); chk("t6_pc14", pc_o, 32'h14);
    yags_taken_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
